// File: rtl/mulpop_pkg.sv
// Shared types and constants for the multiply/popcount sequencer.
package mulpop_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        POP,
        DONE
    } state_t;

    localparam int AW_DEF    = 24;
    localparam int RW_DEF    = 32;
    localparam int CW_DEF    = 16;
    localparam int B_DONE    = 1;
    localparam int B_VALID   = 0;
    localparam int POP_STEPS = RW_DEF / 8;

    function automatic logic [3:0] pop8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, b[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mulpop_sched_rr_arbiter.sv
// Combinational round-robin arbiter; the last-grant pointer lives in the parent.
module rr_arbiter
    import mulpop_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_id,
    output logic            o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic          w_hit;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        w_hit = 1'b0;
        w_sum = '0;
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(i + 1);
            if (w_sum >= (IW+1)'(NREQ))
                w_sum = w_sum - (IW+1)'(NREQ);
            w_idx = w_sum[IW-1:0];
            if (!w_hit && i_req[w_idx]) begin
                w_hit        = 1'b1;
                o_id         = w_idx;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mulpop_sched.sv
// Shares one shift-add multiplier and byte-serial popcount between NREQ
// requesters; returns low product word, its ones count and a status pair.
module mulpop_sched
    import mulpop_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = AW_DEF,
    parameter int RW   = RW_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      op_a1,
    input  logic [NREQ*AW-1:0]      op_a2,
    input  logic                    abort,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [RW-1:0]           res_w,
    output logic [AW-1:0]           res_l,
    output logic [1:0]              res_b,
    output logic [CW-1:0]           op_count
);

    localparam int IW   = $clog2(NREQ);
    localparam int PW   = 2 * AW;
    localparam int NPOP = RW / 8;
    localparam int KW   = $clog2(AW + NPOP);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gid;
    logic [KW-1:0]   r_k;
    logic [PW-1:0]   r_a1;
    logic [AW-1:0]   r_a2;
    logic [PW-1:0]   r_acc;
    logic [AW-1:0]   r_pcnt;
    logic [NREQ-1:0] r_ack;
    logic [RW-1:0]   r_res_w;
    logic [AW-1:0]   r_res_l;
    logic [1:0]      r_res_b;
    logic [CW-1:0]   r_cnt;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_id;
    logic            w_any;
    logic [AW-1:0]   w_a1;
    logic [AW-1:0]   w_a2;
    logic [7:0]      w_byte;
    logic            w_hi_zero;
    logic [NREQ-1:0] w_onehot;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_id),
        .o_any (w_any)
    );

    // One-hot AND-OR operand mux driven by the arbiter grant.
    always_comb begin
        w_a1 = '0;
        w_a2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a1 = w_a1 | op_a1[i*AW +: AW];
                w_a2 = w_a2 | op_a2[i*AW +: AW];
            end
        end
    end

    assign w_byte    = 8'(r_acc[RW-1:0] >> {r_k, 3'b000});
    assign w_hi_zero = ((r_acc >> RW) == '0);
    assign w_onehot  = NREQ'(1) << r_gid;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_any) w_next = MULT;
            MULT: begin
                if (abort)
                    w_next = IDLE;
                else if (r_k == KW'(AW - 1))
                    w_next = POP;
            end
            POP: begin
                if (abort)
                    w_next = IDLE;
                else if (r_k == KW'(NPOP - 1))
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ptr   <= IW'(NREQ - 1);
            r_gid   <= '0;
            r_k     <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_acc   <= '0;
            r_pcnt  <= '0;
            r_ack   <= '0;
            r_res_w <= '0;
            r_res_l <= '0;
            r_res_b <= '0;
            r_cnt   <= '0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr  <= w_id;
                        r_gid  <= w_id;
                        r_k    <= '0;
                        r_a1   <= PW'(w_a1);
                        r_a2   <= w_a2;
                        r_acc  <= '0;
                        r_pcnt <= '0;
                    end
                end
                MULT: begin
                    if (r_a2[0])
                        r_acc <= r_acc + r_a1;
                    r_a1 <= r_a1 << 1;
                    r_a2 <= r_a2 >> 1;
                    r_k  <= (r_k == KW'(AW - 1)) ? '0 : r_k + 1'b1;
                end
                POP: begin
                    r_pcnt <= r_pcnt + AW'(pop8(w_byte));
                    r_k    <= r_k + 1'b1;
                end
                DONE: begin
                    r_ack            <= w_onehot;
                    r_res_w          <= r_acc[RW-1:0];
                    r_res_l          <= r_pcnt;
                    r_res_b[B_DONE]  <= 1'b1;
                    r_res_b[B_VALID] <= w_hi_zero;
                    r_cnt            <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ack      = r_ack;
    assign grant_id = r_gid;
    assign busy     = (r_state != IDLE);
    assign res_w    = r_res_w;
    assign res_l    = r_res_l;
    assign res_b    = r_res_b;
    assign op_count = r_cnt;

endmodule

// File: tb/tb_mulpop_sched.sv
// Directed bench for mulpop_sched: latency, results, round-robin order,
// abort and mid-operation reset.
module tb_mulpop_sched;

    logic        clk;
    logic        n_reset;
    logic [1:0]  req;
    logic [47:0] op_a1;
    logic [47:0] op_a2;
    logic        abort;
    logic [1:0]  ack;
    logic [0:0]  grant_id;
    logic        busy;
    logic [31:0] res_w;
    logic [23:0] res_l;
    logic [1:0]  res_b;
    logic [15:0] op_count;

    int n_chk;
    int n_fail;
    int cyc;

    mulpop_sched dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .req      (req),
        .op_a1    (op_a1),
        .op_a2    (op_a2),
        .abort    (abort),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .res_w    (res_w),
        .res_l    (res_l),
        .res_b    (res_b),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        n_reset = 1'b0;
        req     = 2'b00;
        abort   = 1'b0;
        op_a1   = '0;
        op_a2   = '0;
        repeat (2) @(negedge clk);
        n_chk++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b want 00", ack); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_gid: got %b want 0", grant_id); end
        n_chk++; if (res_w !== 32'h0) begin n_fail++; $display("FAIL rst_w: got %h want 0", res_w); end
        n_chk++; if (res_l !== 24'h0) begin n_fail++; $display("FAIL rst_l: got %h want 0", res_l); end
        n_chk++; if (res_b !== 2'b00) begin n_fail++; $display("FAIL rst_b: got %b want 00", res_b); end
        n_chk++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", op_count); end
        n_reset = 1'b1;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy %b want 0", busy); end
    endtask

    task automatic test_basic();
        int  t0;
        bit  got;
        @(negedge clk);
        op_a1[23:0] = 24'h000003;
        op_a2[23:0] = 24'h000005;
        req = 2'b01;
        t0  = cyc + 1;
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL basic_gid: got %b want 0", grant_id); end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) got = 1'b1;
        end
        req = 2'b00;
        n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got no ack, want ack"); end
        n_chk++; if (cyc - t0 !== 29) begin n_fail++; $display("FAIL basic_lat: got %0d want 29", cyc - t0); end
        n_chk++; if (ack !== 2'b01) begin n_fail++; $display("FAIL basic_ack: got %b want 01", ack); end
        n_chk++; if (res_w !== 32'h0000000F) begin n_fail++; $display("FAIL basic_w: got %h want 0000000f", res_w); end
        n_chk++; if (res_l !== 24'd4) begin n_fail++; $display("FAIL basic_l: got %0d want 4", res_l); end
        n_chk++; if (res_b !== 2'b11) begin n_fail++; $display("FAIL basic_b: got %b want 11", res_b); end
        n_chk++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", op_count); end
        @(negedge clk);
        n_chk++; if (ack !== 2'b00) begin n_fail++; $display("FAIL basic_pulse: got %b want 00", ack); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_regrant: busy %b want 0", busy); end
    endtask

    task automatic test_overflow();
        bit got;
        @(negedge clk);
        op_a1[47:24] = 24'hFFFFFF;
        op_a2[47:24] = 24'hFFFFFF;
        req = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) got = 1'b1;
        end
        req = 2'b00;
        n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL ovf_timeout: got no ack, want ack"); end
        n_chk++; if (ack !== 2'b10) begin n_fail++; $display("FAIL ovf_ack: got %b want 10", ack); end
        n_chk++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL ovf_gid: got %b want 1", grant_id); end
        n_chk++; if (res_w !== 32'hFE000001) begin n_fail++; $display("FAIL ovf_w: got %h want fe000001", res_w); end
        n_chk++; if (res_l !== 24'd8) begin n_fail++; $display("FAIL ovf_l: got %0d want 8", res_l); end
        n_chk++; if (res_b !== 2'b10) begin n_fail++; $display("FAIL ovf_b: got %b want 10", res_b); end
        n_chk++; if (op_count !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 2", op_count); end
    endtask

    task automatic test_back_to_back();
        int          n;
        bit          ovl;
        int          ids [3];
        int          cycs[3];
        logic [31:0] ws  [3];
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        n_reset = 1'b1;
        op_a1 = {24'h000007, 24'h000002};
        op_a2 = {24'h000009, 24'h000003};
        req   = 2'b11;
        n   = 0;
        ovl = 1'b0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk);
            if ($countones(ack) > 1) ovl = 1'b1;
            if (ack !== 2'b00) begin
                ids[n]  = int'(ack[1]);
                cycs[n] = cyc;
                ws[n]   = res_w;
                n++;
                if (n == 3) req = 2'b00;
            end
        end
        n_chk++; if (n !== 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d acks want 3", n); end
        if (n == 3) begin
            n_chk++; if (ids[0] !== 0) begin n_fail++; $display("FAIL b2b_id0: got %0d want 0", ids[0]); end
            n_chk++; if (ids[1] !== 1) begin n_fail++; $display("FAIL b2b_id1: got %0d want 1", ids[1]); end
            n_chk++; if (ids[2] !== 0) begin n_fail++; $display("FAIL b2b_id2: got %0d want 0", ids[2]); end
            n_chk++; if (cycs[1] - cycs[0] !== 30) begin n_fail++; $display("FAIL b2b_gap01: got %0d want 30", cycs[1] - cycs[0]); end
            n_chk++; if (cycs[2] - cycs[1] !== 30) begin n_fail++; $display("FAIL b2b_gap12: got %0d want 30", cycs[2] - cycs[1]); end
            n_chk++; if (ws[0] !== 32'h6) begin n_fail++; $display("FAIL b2b_w0: got %h want 6", ws[0]); end
            n_chk++; if (ws[1] !== 32'h3F) begin n_fail++; $display("FAIL b2b_w1: got %h want 3f", ws[1]); end
            n_chk++; if (ws[2] !== 32'h6) begin n_fail++; $display("FAIL b2b_w2: got %h want 6", ws[2]); end
        end
        n_chk++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap: got %b want 0", ovl); end
        n_chk++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 3", op_count); end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b want 0", busy); end
    endtask

    task automatic test_abort();
        bit saw;
        bit got;
        @(negedge clk);
        op_a1 = {24'h000100, 24'h000010};
        op_a2 = {24'h000003, 24'h000010};
        req   = 2'b01;
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abt_busy: got %b want 1", busy); end
        n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL abt_gid0: got %b want 0", grant_id); end
        saw = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (ack !== 2'b00) saw = 1'b1;
        end
        abort = 1'b1;
        req   = 2'b11;
        @(negedge clk);
        abort = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abt_idle: busy %b want 0", busy); end
        n_chk++; if (ack !== 2'b00 || saw) begin n_fail++; $display("FAIL abt_noack: ack %b seen %b want none", ack, saw); end
        n_chk++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL abt_cnt: got %0d want 3", op_count); end
        n_chk++; if (res_w !== 32'h6) begin n_fail++; $display("FAIL abt_hold: got %h want 6", res_w); end
        @(negedge clk);
        n_chk++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL abt_rr: got %b want 1", grant_id); end
        req = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) got = 1'b1;
        end
        req = 2'b00;
        n_chk++; if (ack !== 2'b10) begin n_fail++; $display("FAIL abt_ack1: got %b want 10", ack); end
        n_chk++; if (res_w !== 32'h300) begin n_fail++; $display("FAIL abt_w1: got %h want 300", res_w); end
        n_chk++; if (res_l !== 24'd2) begin n_fail++; $display("FAIL abt_l1: got %0d want 2", res_l); end
        n_chk++; if (op_count !== 16'd4) begin n_fail++; $display("FAIL abt_cnt1: got %0d want 4", op_count); end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit got;
        @(negedge clk);
        op_a1[23:0] = 24'h000055;
        op_a2[23:0] = 24'h000001;
        req = 2'b01;
        repeat (26) @(negedge clk);
        req = 2'b00;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_pop: busy %b want 1", busy); end
        n_reset = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_chk++; if (res_w !== 32'h0) begin n_fail++; $display("FAIL rm_w: got %h want 0", res_w); end
        n_chk++; if (res_l !== 24'h0) begin n_fail++; $display("FAIL rm_l: got %h want 0", res_l); end
        n_chk++; if (res_b !== 2'b00) begin n_fail++; $display("FAIL rm_b: got %b want 00", res_b); end
        n_chk++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", op_count); end
        n_chk++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rm_gid: got %b want 0", grant_id); end
        @(negedge clk);
        n_reset = 1'b1;
        op_a1[23:0] = 24'h000000;
        op_a2[23:0] = 24'hFFFFFF;
        req = 2'b01;
        t0  = cyc + 1;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) got = 1'b1;
        end
        req = 2'b00;
        n_chk++; if (cyc - t0 !== 29) begin n_fail++; $display("FAIL rm_lat: got %0d want 29", cyc - t0); end
        n_chk++; if (ack !== 2'b01) begin n_fail++; $display("FAIL rm_ack: got %b want 01", ack); end
        n_chk++; if (res_w !== 32'h0) begin n_fail++; $display("FAIL rm_w2: got %h want 0", res_w); end
        n_chk++; if (res_l !== 24'd0) begin n_fail++; $display("FAIL rm_l2: got %0d want 0", res_l); end
        n_chk++; if (res_b !== 2'b11) begin n_fail++; $display("FAIL rm_b2: got %b want 11", res_b); end
        n_chk++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL rm_cnt2: got %0d want 1", op_count); end
    endtask

    task automatic test_abort_done();
        @(negedge clk);
        op_a1[23:0] = 24'h000001;
        op_a2[23:0] = 24'h000001;
        req = 2'b01;
        repeat (29) @(negedge clk);
        n_chk++; if (busy !== 1'b1 || ack !== 2'b00) begin n_fail++; $display("FAIL ad_done: busy %b ack %b want 1 00", busy, ack); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        req   = 2'b00;
        n_chk++; if (ack !== 2'b01) begin n_fail++; $display("FAIL ad_ack: got %b want 01", ack); end
        n_chk++; if (op_count !== 16'd2) begin n_fail++; $display("FAIL ad_cnt: got %0d want 2", op_count); end
        n_chk++; if (res_w !== 32'h1) begin n_fail++; $display("FAIL ad_w: got %h want 1", res_w); end
        n_chk++; if (res_b !== 2'b11) begin n_fail++; $display("FAIL ad_b: got %b want 11", res_b); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_abort_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
